sprite_line_fetcher: RTL and testbench

- Sprite scanline fetch engine; sits directly upstream of the sprite pattern memory (64 patterns, 16x16, 2-bit pixels, 14-bit address, 1-cycle registered read).
- During horizontal blank, walks the sprite attribute table, finds sprites that intersect the next scanline, reads their 16 pixels for that row, and writes the opaque ones into the downstream scanline buffer.
- The scanline buffer is read by the pixel mixer during active video.

---
 rtl/sprite_line_fetcher.sv | 207 ++++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetcher.sv
// Sprite scanline fetch engine: scans the attribute table during hblank and writes
// opaque pixels of intersecting sprites into the scanline buffer. Optional macro: SPRITE_FLIP_EN.
module sprite_line_fetcher #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned H_RES       = 640
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_line_start,
  input  logic [9:0]                     i_line_num,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [$clog2(NUM_SPRITES)-1:0] o_attr_raddr,
  input  logic [28:0]                    i_attr_rdata,
  output logic                           o_spr_ren,
  output logic [13:0]                    o_spr_raddr,
  input  logic [1:0]                     i_spr_rdata,
  output logic                           o_lb_wen,
  output logic [9:0]                     o_lb_waddr,
  output logic [1:0]                     o_lb_wdata
);

  localparam int unsigned SW = $clog2(NUM_SPRITES);
  localparam logic [SW-1:0] SLOT_TOP = SW'(NUM_SPRITES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ATTR  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    r_state, w_state_n;
  logic [9:0]    r_line, w_line_n;
  logic [SW-1:0] r_slot, w_slot_n;
  logic [5:0]    r_idx, w_idx_n;
  logic [9:0]    r_x, w_x_n;
  logic [3:0]    r_row, w_row_n;
  logic [3:0]    r_col, w_col_n;
  logic          r_more, w_more_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic          r_spr_ren, w_ren_n;
  logic [13:0]   r_spr_raddr, w_raddr_n;
  logic [10:0]   r_rd_x, w_rd_x_n;
  logic          r_p_vld;
  logic [10:0]   r_p_x;
  logic          r_lb_wen;
  logic [9:0]    r_lb_waddr;
  logic [1:0]    r_lb_wdata;

  logic [9:0]    w_dy;
  logic          w_hit;
  logic [3:0]    w_row_hit;
  logic [3:0]    w_col0;
  logic [3:0]    w_col_next;
  logic [3:0]    w_col_addr;
  logic [10:0]   w_rd_x_next;
  logic          w_wen;

  // Modular distance lets sprites with y near 1023 cover the top lines.
  assign w_dy        = r_line - i_attr_rdata[19:10];
  assign w_hit       = i_attr_rdata[28] && (w_dy[9:4] == 6'd0);
  assign w_col_next  = r_col + 4'd1;
  assign w_rd_x_next = {1'b0, r_x} + 11'(w_col_next);

`ifdef SPRITE_FLIP_EN
  logic r_hflip;
  assign w_row_hit  = i_attr_rdata[27] ? (4'd15 - w_dy[3:0]) : w_dy[3:0];
  assign w_col0     = i_attr_rdata[26] ? 4'd15 : 4'd0;
  assign w_col_addr = r_hflip ? ~w_col_next : w_col_next;

  always_ff @(posedge i_clk) begin
    if (i_reset)                        r_hflip <= 1'b0;
    else if (r_state == S_CHECK && w_hit) r_hflip <= i_attr_rdata[26];
  end
`else
  logic w_unused_flip;
  assign w_unused_flip = ^i_attr_rdata[27:26];
  assign w_row_hit     = w_dy[3:0];
  assign w_col0        = 4'd0;
  assign w_col_addr    = w_col_next;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_n = r_state;
    w_line_n  = r_line;
    w_slot_n  = r_slot;
    w_idx_n   = r_idx;
    w_x_n     = r_x;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_more_n  = r_more;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_ren_n   = 1'b0;
    w_raddr_n = r_spr_raddr;
    w_rd_x_n  = r_rd_x;
    case (r_state)
      S_IDLE: ;
      S_ATTR: w_state_n = S_CHECK;
      S_CHECK: begin
        if (w_hit) begin
          w_idx_n   = i_attr_rdata[25:20];
          w_x_n     = i_attr_rdata[9:0];
          w_row_n   = w_row_hit;
          w_col_n   = 4'd0;
          w_ren_n   = 1'b1;
          w_raddr_n = {i_attr_rdata[25:20], w_row_hit, w_col0};
          w_rd_x_n  = {1'b0, i_attr_rdata[9:0]};
          w_state_n = S_FETCH;
        end else if (r_slot == '0) begin
          w_state_n = S_DRAIN;
        end else begin
          w_slot_n  = r_slot - SW'(1);
          w_state_n = S_ATTR;
        end
      end
      S_FETCH: begin
        // Address the next slot during the last read so its CHECK follows directly.
        if (r_col == 4'd14) begin
          w_more_n = (r_slot != '0);
          if (r_slot != '0) w_slot_n = r_slot - SW'(1);
        end
        if (r_col == 4'd15) begin
          w_state_n = r_more ? S_CHECK : S_DRAIN;
        end else begin
          w_col_n   = w_col_next;
          w_ren_n   = 1'b1;
          w_raddr_n = {r_idx, r_row, w_col_addr};
          w_rd_x_n  = w_rd_x_next;
        end
      end
      S_DRAIN: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
    // A new line start always restarts the scan, aborting any fetch in flight.
    if (i_line_start) begin
      w_line_n  = i_line_num;
      w_slot_n  = SLOT_TOP;
      w_state_n = S_ATTR;
      w_busy_n  = 1'b1;
      w_done_n  = 1'b0;
      w_ren_n   = 1'b0;
    end
  end

  assign w_wen = r_p_vld && (i_spr_rdata != 2'd0) && (r_p_x < 11'(H_RES));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_line      <= 10'd0;
      r_slot      <= '0;
      r_idx       <= 6'd0;
      r_x         <= 10'd0;
      r_row       <= 4'd0;
      r_col       <= 4'd0;
      r_more      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_spr_ren   <= 1'b0;
      r_spr_raddr <= 14'd0;
      r_rd_x      <= 11'd0;
      r_p_vld     <= 1'b0;
      r_p_x       <= 11'd0;
      r_lb_wen    <= 1'b0;
      r_lb_waddr  <= 10'd0;
      r_lb_wdata  <= 2'd0;
    end else begin
      r_state     <= w_state_n;
      r_line      <= w_line_n;
      r_slot      <= w_slot_n;
      r_idx       <= w_idx_n;
      r_x         <= w_x_n;
      r_row       <= w_row_n;
      r_col       <= w_col_n;
      r_more      <= w_more_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_spr_ren   <= w_ren_n;
      r_spr_raddr <= w_raddr_n;
      r_rd_x      <= w_rd_x_n;
      r_p_vld     <= r_spr_ren;
      r_p_x       <= r_rd_x;
      r_lb_wen    <= w_wen;
      if (w_wen) begin
        r_lb_waddr <= r_p_x[9:0];
        r_lb_wdata <= i_spr_rdata;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_attr_raddr = r_slot;
  assign o_spr_ren    = r_spr_ren;
  assign o_spr_raddr  = r_spr_raddr;
  assign o_lb_wen     = r_lb_wen;
  assign o_lb_waddr   = r_lb_waddr;
  assign o_lb_wdata   = r_lb_wdata;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher: a line-level reference model queues the
// expected reads, writes and done pulses; a negedge monitor pops and compares them.
module tb_sprite_line_fetcher;

  localparam int unsigned NS = 8;
  localparam int unsigned HR = 640;
  localparam int BIG = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  line_num = 10'd0;
  logic        busy, done, spr_ren, lb_wen;
  logic [2:0]  attr_raddr;
  logic [28:0] attr_rdata;
  logic [13:0] spr_raddr;
  logic [1:0]  spr_rdata, lb_wdata;
  logic [9:0]  lb_waddr;

  logic [28:0] attr_mem [NS];
  logic [1:0]  pat [16384];
  int          lb_shadow [1024];

  sprite_line_fetcher #(.NUM_SPRITES(NS), .H_RES(HR)) dut (
    .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_line_num(line_num),
    .o_busy(busy), .o_done(done), .o_attr_raddr(attr_raddr), .i_attr_rdata(attr_rdata),
    .o_spr_ren(spr_ren), .o_spr_raddr(spr_raddr), .i_spr_rdata(spr_rdata),
    .o_lb_wen(lb_wen), .o_lb_waddr(lb_waddr), .o_lb_wdata(lb_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle registered attribute and pattern memories.
  always @(posedge clk) begin
    attr_rdata <= attr_mem[attr_raddr];
    if (spr_ren === 1'b1) spr_rdata <= pat[spr_raddr];
  end

  typedef struct { int c; int a; int d; } ev_t;
  ev_t rq[$];
  ev_t wq[$];
  int  dq[$];
  ev_t me;
  int  md;
  int  n_tests = 0;
  int  n_fail = 0;
  int  n_wen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (spr_ren === 1'b1) begin
      if (rq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spr_read_unexpected: addr 0x%0h at cycle %0d, no read required", spr_raddr, cyc);
      end else begin
        me = rq.pop_front();
        chk("spr_raddr", int'(spr_raddr), me.a);
        chk("spr_read_cycle", cyc, me.c);
      end
    end
    if (lb_wen === 1'b1) begin
      n_wen++;
      lb_shadow[lb_waddr] = int'(lb_wdata);
      if (wq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL lb_write_unexpected: x=%0d data=%0d at cycle %0d, no write required", lb_waddr, lb_wdata, cyc);
      end else begin
        me = wq.pop_front();
        chk("lb_waddr", int'(lb_waddr), me.a);
        chk("lb_wdata", int'(lb_wdata), me.d);
        chk("lb_write_cycle", cyc, me.c);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_unexpected: done pulse at cycle %0d, none required", cyc);
      end else begin
        md = dq.pop_front();
        chk("done_cycle", cyc, md);
      end
    end
  end

  // Line-level reference: slots scanned high to low; a miss costs ATTR+CHECK, a hit
  // costs ATTR+CHECK+16 reads with the next slot's lookup overlapping the last read.
  task automatic gen_line(input int t0, input int line, input int rcut, input int wcut, input bit do_done);
    int a, end_c, en, vf, hf, idx, y, x, dy, row, cola, addr, rc, pix;
    logic [28:0] e;
    a = t0 + 1;
    end_c = a;
    for (int s = int'(NS) - 1; s >= 0; s--) begin
      e = attr_mem[s];
      en = int'(e[28]); vf = int'(e[27]); hf = int'(e[26]);
      idx = int'(e[25:20]); y = int'(e[19:10]); x = int'(e[9:0]);
      dy = ((line - y) % 1024 + 1024) % 1024;
      if (en == 1 && dy < 16) begin
        row = dy;
`ifdef SPRITE_FLIP_EN
        if (vf == 1) row = 15 - dy;
`endif
        for (int c = 0; c < 16; c++) begin
          cola = c;
`ifdef SPRITE_FLIP_EN
          if (hf == 1) cola = 15 - c;
`endif
          addr = idx * 256 + row * 16 + cola;
          rc = a + 2 + c;
          if (rc <= rcut) rq.push_back('{rc, addr, 0});
          pix = int'(pat[addr]);
          if (rc <= wcut && pix != 0 && x + c < int'(HR)) wq.push_back('{rc + 2, x + c, pix});
        end
        end_c = a + 18;
        a = a + 17;
      end else begin
        end_c = a + 2;
        a = a + 2;
      end
    end
    if (do_done) dq.push_back(end_c + 1);
  endtask

  task automatic start_line(input int line, output int t0);
    @(posedge clk);
    #1;
    line_num = 10'(line);
    line_start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (rq.size() == 0 && wq.size() == 0 && dq.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("outstanding_events", rq.size() + wq.size() + dq.size(), 0);
    rq.delete(); wq.delete(); dq.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_spr_ren"}, int'(spr_ren), 0);
    chk({tag, "_lb_wen"}, int'(lb_wen), 0);
    chk({tag, "_attr_raddr"}, int'(attr_raddr), 0);
    chk({tag, "_spr_raddr"}, int'(spr_raddr), 0);
    chk({tag, "_lb_waddr"}, int'(lb_waddr), 0);
    chk({tag, "_lb_wdata"}, int'(lb_wdata), 0);
  endtask

  task automatic clear_attr();
    for (int s = 0; s < int'(NS); s++) attr_mem[s] = {1'b0, 28'($urandom)};
  endtask

  function automatic logic [28:0] mk_attr(input int idx, input int y, input int x);
    return {1'b1, 2'b00, 6'(idx), 10'(y), 10'(x)};
  endfunction

  int t0, t1, k, w0, line, base;

  initial begin
    for (int i = 0; i < 16384; i++) pat[i] = 2'($urandom);
    for (int i = 0; i < 1024; i++) lb_shadow[i] = 0;
    clear_attr();

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // All slots disabled.
    start_line(5, t0);
    gen_line(t0, 5, BIG, BIG, 1);
    chk("allmiss_busy_c1", int'(busy), 1);
    repeat (16) @(posedge clk);
    #1;
    chk("allmiss_busy_c17", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("allmiss_busy_c18", int'(busy), 0);
    wait_idle();

    // Single hit in slot 3, row pattern k%4.
    attr_mem[3] = mk_attr(2, 100, 40);
    for (int c = 0; c < 16; c++) pat[2 * 256 + 3 * 16 + c] = 2'(c % 4);
    w0 = n_wen;
    start_line(103, t0);
    gen_line(t0, 103, BIG, BIG, 1);
    wait_idle();
    chk("slot3_write_count", n_wen - w0, 12);

    // Overlap of slots 1 and 0: slot 0 must own every shared pixel.
    clear_attr();
    attr_mem[1] = mk_attr(5, 50, 200);
    attr_mem[0] = mk_attr(6, 50, 200);
    for (int c = 0; c < 16; c++) begin
      pat[5 * 256 + 7 * 16 + c] = 2'(1 + (c % 3));
      pat[6 * 256 + 7 * 16 + c] = 2'(3 - (c % 3));
    end
    start_line(57, t0);
    gen_line(t0, 57, BIG, BIG, 1);
    wait_idle();
    for (int c = 0; c < 16; c++) chk("overlap_slot0_wins", lb_shadow[200 + c], 3 - (c % 3));

    // Right-edge clipping.
    clear_attr();
    attr_mem[0] = mk_attr(7, 300, 630);
    for (int c = 0; c < 16; c++) pat[7 * 256 + c] = 2'(1 + (c % 3));
    w0 = n_wen;
    start_line(300, t0);
    gen_line(t0, 300, BIG, BIG, 1);
    wait_idle();
    chk("clip_write_count", n_wen - w0, 10);

    // Restart while fetching slot 5.
    clear_attr();
    attr_mem[5] = mk_attr(9, 400, 10);
    attr_mem[2] = mk_attr(11, 402, 700);
    for (int r = 0; r < 3; r++) begin
      k = int'($urandom_range(0, 14));
      start_line(405, t0);
      gen_line(t0, 405, t0 + 7 + k, t0 + 7 + k, 0);
      repeat (5 + k) @(posedge clk);
      start_line(410, t1);
      gen_line(t1, 410, BIG, BIG, 1);
      wait_idle();
    end

    // Reset in the middle of a fetch; pending write must be dropped.
    k = int'($urandom_range(2, 14));
    start_line(405, t0);
    gen_line(t0, 405, t0 + 7 + k, t0 + 5 + k, 0);
    repeat (5 + k) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    reset = 1'b0;
    wait_idle();
    start_line(408, t0);
    gen_line(t0, 408, BIG, BIG, 1);
    wait_idle();

    // Randomized tables and lines, including wrap at the top edge.
    for (int it = 0; it < 25; it++) begin
      line = (it % 5 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1023));
      for (int s = 0; s < int'(NS); s++) begin
        base = ((line - int'($urandom_range(0, 24))) % 1024 + 1024) % 1024;
        attr_mem[s] = {1'($urandom), 2'($urandom), 6'($urandom), 10'(base), 10'($urandom)};
      end
      start_line(line, t0);
      gen_line(t0, line, BIG, BIG, 1);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
